muldiv_sequencer: RTL

Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage. It accepts one operation per request and sequences a 32-step shift-add multiply or restoring divide over operand magnitudes, applying sign fix-up at the end. The result is returned on a valid/ready response port, so the pipeline can stall on `req_ready`/`resp_valid`.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 29 ++
 rtl/muldiv_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// The op enum matches the funct3 field so it can be latched straight from the instruction.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;
  localparam int          STEPS      = 32;

  // Two's-complement magnitude; INT_MIN maps to itself and is read as unsigned.
  function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath on the 64-bit working register:
// shift-add for multiply ({hi,lo}) or restoring subtract for divide ({rem,quot}).
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        is_div,
  input  logic [63:0] work,
  input  logic [31:0] operand,
  output logic [63:0] next
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    sum     = {1'b0, work[63:32]} + (work[0] ? {1'b0, operand} : 33'd0);
    // Remainder shifted left with the next quotient bit brought in; 33 bits keeps the borrow.
    shifted = work[63:31];
    diff    = shifted - {1'b0, operand};
    if (is_div) begin
      if (!diff[32]) next = {diff[31:0], work[30:0], 1'b1};
      else           next = {shifted[31:0], work[30:0], 1'b0};
    end else begin
      next = {sum, work[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-step magnitude datapath with a final sign fix-up.
// Handshakes: a transfer happens on a port in any cycle where valid && ready at the rising edge.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output muldiv_state_e   dbg_state
);

  muldiv_state_e   state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  muldiv_op_e      op_q, op_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [2*XLEN-1:0] work_q, work_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            a_signed, b_signed, sa, sb, is_div_req;
  logic [XLEN-1:0] mag_a, mag_b, quo, rem;
  logic [2*XLEN-1:0] prod, step_next;

  muldiv_step u_step (
    .is_div  (op_q[2]),
    .work    (work_q),
    .operand (opnd_q),
    .next    (step_next)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    result_d = result_q;

    a_signed   = (req_op != MULHU) && (req_op != DIVU) && (req_op != REMU);
    b_signed   = a_signed && (req_op != MULHSU);
    sa         = a_signed && req_a[XLEN-1];
    sb         = b_signed && req_b[XLEN-1];
    mag_a      = abs_val(req_a, a_signed);
    mag_b      = abs_val(req_b, b_signed);
    is_div_req = req_op[2];

    prod = neg_q  ? (~work_q + 64'd1) : work_q;
    quo  = neg_q  ? (~work_q[XLEN-1:0] + 32'd1) : work_q[XLEN-1:0];
    rem  = rneg_q ? (~work_q[2*XLEN-1:XLEN] + 32'd1) : work_q[2*XLEN-1:XLEN];

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d   = muldiv_op_e'(req_op);
          neg_d  = sa ^ sb;
          rneg_d = sa;
          cnt_d  = 5'd31;
          if (is_div_req && (req_b == '0)) begin
            result_d = req_op[1] ? req_a : DIV_ZERO_Q;
            state_d  = DONE;
          end else if (is_div_req && !req_op[0] && (req_a == INT_MIN) && (req_b == '1)) begin
            result_d = req_op[1] ? '0 : INT_MIN;
            state_d  = DONE;
          end else begin
            state_d = CALC;
            if (is_div_req) begin
              work_d = {{XLEN{1'b0}}, mag_a};
              opnd_d = mag_b;
            end else begin
              work_d = {{XLEN{1'b0}}, mag_b};
              opnd_d = mag_a;
            end
          end
        end
      end
      CALC: begin
        work_d = step_next;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = SIGN;
      end
      SIGN: begin
        case (op_q)
          MUL:                 result_d = prod[XLEN-1:0];
          MULH, MULHSU, MULHU: result_d = prod[2*XLEN-1:XLEN];
          DIV, DIVU:           result_d = quo;
          default:             result_d = rem;
        endcase
        state_d = DONE;
      end
      default: begin
        if (resp_ready) state_d = IDLE;
      end
    endcase

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd31;
      op_q     <= MUL;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      work_q   <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == DONE);
  assign resp_result = resp_valid ? result_q : '0;
  assign dbg_state   = state_q;

endmodule
